pc_redirect_ctrl: RTL and testbench
===================================

# pc_redirect_ctrl

Sequencing controller for the fetch-stage program counter. It arbitrates between redirect sources: trap entry, trap return (mret), EX-stage taken branch and ID-stage jump. It merges the stall sources into a single PC stall and holds a redirect that arrives while the PC is stalled until the PC can take it. It drives the PC's next-select, target and stall inputs, plus the IF/ID and ID/EX flush strobes.

## Interface
- XLEN, 32, address/target width.
- CLK  input  1  clock, all state on rising edge.
- RST  input  1  synchronous, active-high reset.
- hazard_stall  input  1  load-use stall from hazard unit.
- imem_stall  input  1  instruction memory not ready.
- br_taken  input  1  EX-stage branch resolved taken.
- br_target  input  XLEN  branch target.
- jmp_valid  input  1  ID-stage JAL/JALR.
- jmp_target  input  XLEN  jump target.
- trap_req  input  1  exception/interrupt entry (TRAP_EN only).
- trap_vector  input  XLEN  trap handler address (TRAP_EN only).
- mret_req  input  1  trap return (TRAP_EN only).
- mret_target  input  XLEN  saved return PC (TRAP_EN only).
- PC_next_sel  output  1  PC loads PC_jump_branch this cycle.
- PC_jump_branch  output  XLEN  redirect target.
- PC_stall  output  1  PC holds.
- flush_if_id  output  1  one-cycle IF/ID bubble strobe.
- flush_id_ex  output  1  one-cycle ID/EX bubble strobe.
- misalign_err  output  1  one-cycle pulse, dropped redirect with target[1:0] != 0.

## Operation
- Priority: trap (3) > mret (2) > branch (1) > jump (0). Only the highest active source is taken. Lower ones are discarded, because they are on the wrong path.
- A source is valid only if its target[1:0] == 2'b00. A misaligned winner is dropped: misalign_err = 1 for that cycle, no redirect, no flush, and lower sources are also discarded that cycle.
- FSM states: RUN, HOLD.
- RUN, stall_any = hazard_stall | imem_stall:
  - Winner and stall_any = 0: PC_next_sel = 1 and PC_jump_branch = winner target, combinationally in the same cycle. Stay in RUN.
  - Winner and stall_any = 1: capture target and 2-bit priority into the pending register. Go to HOLD. PC_next_sel = 0.
- HOLD:
  - A new valid source with priority >= pending priority overwrites the pending register. A lower-priority source is ignored.
  - When stall_any = 0: PC_next_sel = 1 with the pending target (or the same-cycle overwrite target). Clear pending. Go to RUN.
- Flush strobes are asserted in the cycle a redirect is accepted (RUN issue or HOLD capture/overwrite), never in the release cycle:
  - Any source: flush_if_id.
  - Trap, mret or branch: also flush_id_ex.
- PC_stall = stall_any in both states. The PC takes priority on its stall, so PC_next_sel is never asserted with PC_stall = 1.
- PC_jump_branch = 0 whenever PC_next_sel = 0.
- Reset in any state: state = RUN, pending target/priority = 0. All outputs 0 next cycle, except PC_stall, which follows its inputs combinationally.

## Timing
- Redirect latency, unstalled: 0 cycles. The PC register holds the new target on the next edge.
- Redirect during stall: issued in the first cycle stall_any = 0. The PC holds the target one edge later.
- Outputs PC_next_sel, PC_jump_branch, PC_stall and flushes are combinational from inputs plus registered state. misalign_err is combinational.
- A simultaneous stall release and new higher-priority source in HOLD issues the new source's target, not the stale one.
- A back-to-back redirect in consecutive RUN cycles is issued each cycle, with no dead cycle.

## Configuration
- PC_REDIRECT_TRAP_EN defined: trap_req/trap_vector/mret_req/mret_target ports exist, with priorities as above.
- PC_REDIRECT_TRAP_EN undefined: those ports are absent. Only branch and jump are arbitrated, and the pending-priority register is 1 bit.

## Test plan
- Reset: RST = 1 for 2 cycles while br_taken = 1 -> PC_next_sel = 0, flushes = 0, misalign_err = 0, state RUN.
- Unstalled branch: br_taken = 1, br_target = 0x100, jmp_valid = 1, jmp_target = 0x200 -> same cycle PC_next_sel = 1, PC_jump_branch = 0x100, flush_if_id = flush_id_ex = 1.
- Stall hold:
  - imem_stall = 1 for 3 cycles; jmp 0x40 in cycle 1 -> flush_if_id = 1 in cycle 1 only, PC_stall = 1 cycles 1–3.
  - Cycle 4: PC_next_sel = 1, target 0x40.
- Overwrite in HOLD: pending jump 0x40, then br_taken target 0x80 while stalled -> release issues 0x80. A later jmp 0xC0 while branch is pending is ignored.
- Misaligned: br_target = 0x102 -> misalign_err = 1, PC_next_sel = 0, no flush.
- TRAP_EN: trap 0x800 and mret 0x300 simultaneous -> PC_jump_branch = 0x800. Without the macro, the bench compiles with only branch/jump ports.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// ============================================================================
// pc_redirect_ctrl: fetch PC redirect arbiter, stall merge and pending hold.
// Optional trap/mret sources enabled by macro PC_REDIRECT_TRAP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_redirect_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            hazard_stall,
  input  logic            imem_stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp_valid,
  input  logic [XLEN-1:0] jmp_target,
`ifdef PC_REDIRECT_TRAP_EN
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            mret_req,
  input  logic [XLEN-1:0] mret_target,
`endif
  output logic            PC_next_sel,
  output logic [XLEN-1:0] PC_jump_branch,
  output logic            PC_stall,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            misalign_err
);

`ifdef PC_REDIRECT_TRAP_EN
  localparam int PW = 2;
  localparam logic [PW-1:0] P_TRAP = 2'd3;
  localparam logic [PW-1:0] P_MRET = 2'd2;
`else
  localparam int PW = 1;
`endif
  localparam logic [PW-1:0] P_BR  = PW'(1);
  localparam logic [PW-1:0] P_JMP = PW'(0);

  typedef enum logic [0:0] {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pend_tgt_q, pend_tgt_d;
  logic [PW-1:0]     pend_prio_q, pend_prio_d;

  logic              win_any;
  logic [PW-1:0]     win_prio;
  logic [XLEN-1:0]   win_tgt;
  logic              win_ok;
  logic              stall_any;

  assign stall_any = hazard_stall | imem_stall;

  // Only the highest asserted request matters; alignment is judged afterwards
  // so a misaligned winner still suppresses everything below it.
  always_comb begin
    win_any  = 1'b0;
    win_prio = P_JMP;
    win_tgt  = '0;
`ifdef PC_REDIRECT_TRAP_EN
    if (trap_req) begin
      win_any  = 1'b1;
      win_prio = P_TRAP;
      win_tgt  = trap_vector;
    end else if (mret_req) begin
      win_any  = 1'b1;
      win_prio = P_MRET;
      win_tgt  = mret_target;
    end else
`endif
    if (br_taken) begin
      win_any  = 1'b1;
      win_prio = P_BR;
      win_tgt  = br_target;
    end else if (jmp_valid) begin
      win_any  = 1'b1;
      win_prio = P_JMP;
      win_tgt  = jmp_target;
    end
  end

  assign win_ok = win_any && (win_tgt[1:0] == 2'b00);

  always_comb begin
    state_d        = state_q;
    pend_tgt_d     = pend_tgt_q;
    pend_prio_d    = pend_prio_q;
    PC_next_sel    = 1'b0;
    PC_jump_branch = '0;
    PC_stall       = stall_any;
    flush_if_id    = 1'b0;
    flush_id_ex    = 1'b0;
    misalign_err   = 1'b0;
    if (!RST) begin
      misalign_err = win_any && !win_ok;
      case (state_q)
        RUN: begin
          if (win_ok) begin
            flush_if_id = 1'b1;
            flush_id_ex = (win_prio != P_JMP);
            if (stall_any) begin
              pend_tgt_d  = win_tgt;
              pend_prio_d = win_prio;
              state_d     = HOLD;
            end else begin
              PC_next_sel    = 1'b1;
              PC_jump_branch = win_tgt;
            end
          end
        end
        HOLD: begin
          if (win_ok && (win_prio >= pend_prio_q)) begin
            flush_if_id = 1'b1;
            flush_id_ex = (win_prio != P_JMP);
            pend_tgt_d  = win_tgt;
            pend_prio_d = win_prio;
          end
          if (!stall_any) begin
            PC_next_sel    = 1'b1;
            PC_jump_branch = pend_tgt_d;
            pend_tgt_d     = '0;
            pend_prio_d    = '0;
            state_d        = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      pend_tgt_q  <= '0;
      pend_prio_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_prio_q <= pend_prio_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
// ============================================================================
// tb_pc_redirect_ctrl: directed self-checking bench for pc_redirect_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pc_redirect_ctrl;

  logic        CLK, RST;
  logic        hazard_stall, imem_stall, br_taken, jmp_valid;
  logic [31:0] br_target, jmp_target;
`ifdef PC_REDIRECT_TRAP_EN
  logic        trap_req, mret_req;
  logic [31:0] trap_vector, mret_target;
`endif
  logic        PC_next_sel, PC_stall, flush_if_id, flush_id_ex, misalign_err;
  logic [31:0] PC_jump_branch;

  // {next_sel, stall, flush_if_id, flush_id_ex, misalign_err, target}
  logic [36:0] obs;
  assign obs = {PC_next_sel, PC_stall, flush_if_id, flush_id_ex, misalign_err, PC_jump_branch};

  int total = 0;
  int bad   = 0;

  pc_redirect_ctrl #(.XLEN(32)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .hazard_stall   (hazard_stall),
    .imem_stall     (imem_stall),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .jmp_valid      (jmp_valid),
    .jmp_target     (jmp_target),
`ifdef PC_REDIRECT_TRAP_EN
    .trap_req       (trap_req),
    .trap_vector    (trap_vector),
    .mret_req       (mret_req),
    .mret_target    (mret_target),
`endif
    .PC_next_sel    (PC_next_sel),
    .PC_jump_branch (PC_jump_branch),
    .PC_stall       (PC_stall),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .misalign_err   (misalign_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic set_in(input logic hz, input logic im, input logic br,
                        input logic [31:0] brt, input logic jv, input logic [31:0] jt);
    hazard_stall = hz;
    imem_stall   = im;
    br_taken     = br;
    br_target    = brt;
    jmp_valid    = jv;
    jmp_target   = jt;
`ifdef PC_REDIRECT_TRAP_EN
    trap_req    = 1'b0;
    trap_vector = '0;
    mret_req    = 1'b0;
    mret_target = '0;
`endif
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    set_in(0, 0, 1, 32'h100, 0, 0);
    @(negedge CLK);
    total++;
    if (obs !== {5'b00000, 32'h0}) begin
      bad++; $display("FAIL reset_c1 got=%h want=%h", obs, {5'b00000, 32'h0});
    end
    next_cycle();
    set_in(0, 1, 1, 32'h100, 0, 0);
    @(negedge CLK);
    total++;
    if (obs !== {5'b01000, 32'h0}) begin
      bad++; $display("FAIL reset_c2_stall got=%h want=%h", obs, {5'b01000, 32'h0});
    end
    next_cycle();
    RST = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    total++;
    if (obs !== {5'b00000, 32'h0}) begin
      bad++; $display("FAIL post_reset_idle got=%h want=%h", obs, {5'b00000, 32'h0});
    end
    next_cycle();
    set_in(0, 0, 0, 0, 1, 32'h20);
    @(negedge CLK);
    total++;
    if (obs !== {5'b10100, 32'h20}) begin
      bad++; $display("FAIL post_reset_run got=%h want=%h", obs, {5'b10100, 32'h20});
    end
    next_cycle();
  endtask

  task automatic test_unstalled_branch();
    set_in(0, 0, 1, 32'h100, 1, 32'h200);
    @(negedge CLK);
    total++;
    if (obs !== {5'b10110, 32'h100}) begin
      bad++; $display("FAIL br_over_jmp got=%h want=%h", obs, {5'b10110, 32'h100});
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    set_in(0, 0, 0, 0, 1, 32'h200);
    @(negedge CLK);
    total++;
    if (obs !== {5'b10100, 32'h200}) begin
      bad++; $display("FAIL b2b_jmp got=%h want=%h", obs, {5'b10100, 32'h200});
    end
    next_cycle();
    set_in(0, 0, 1, 32'h300, 0, 0);
    @(negedge CLK);
    total++;
    if (obs !== {5'b10110, 32'h300}) begin
      bad++; $display("FAIL b2b_br got=%h want=%h", obs, {5'b10110, 32'h300});
    end
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    total++;
    if (obs !== {5'b00000, 32'h0}) begin
      bad++; $display("FAIL b2b_idle got=%h want=%h", obs, {5'b00000, 32'h0});
    end
    next_cycle();
  endtask

  task automatic test_stall_hold();
    set_in(0, 1, 0, 0, 1, 32'h40);
    @(negedge CLK);
    total++;
    if (obs !== {5'b01100, 32'h0}) begin
      bad++; $display("FAIL hold_c1 got=%h want=%h", obs, {5'b01100, 32'h0});
    end
    next_cycle();
    for (int i = 2; i <= 3; i++) begin
      set_in(0, 1, 0, 0, 0, 0);
      @(negedge CLK);
      total++;
      if (obs !== {5'b01000, 32'h0}) begin
        bad++; $display("FAIL hold_c%0d got=%h want=%h", i, obs, {5'b01000, 32'h0});
      end
      next_cycle();
    end
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    total++;
    if (obs !== {5'b10000, 32'h40}) begin
      bad++; $display("FAIL hold_release got=%h want=%h", obs, {5'b10000, 32'h40});
    end
    next_cycle();
    @(negedge CLK);
    total++;
    if (obs !== {5'b00000, 32'h0}) begin
      bad++; $display("FAIL hold_after got=%h want=%h", obs, {5'b00000, 32'h0});
    end
    next_cycle();
  endtask

  task automatic test_overwrite();
    set_in(1, 0, 0, 0, 1, 32'h40);
    @(negedge CLK);
    total++;
    if (obs !== {5'b01100, 32'h0}) begin
      bad++; $display("FAIL ovw_capture got=%h want=%h", obs, {5'b01100, 32'h0});
    end
    next_cycle();
    set_in(1, 0, 1, 32'h80, 0, 0);
    @(negedge CLK);
    total++;
    if (obs !== {5'b01110, 32'h0}) begin
      bad++; $display("FAIL ovw_branch got=%h want=%h", obs, {5'b01110, 32'h0});
    end
    next_cycle();
    set_in(0, 1, 0, 0, 1, 32'hC0);
    @(negedge CLK);
    total++;
    if (obs !== {5'b01000, 32'h0}) begin
      bad++; $display("FAIL ovw_low_ignored got=%h want=%h", obs, {5'b01000, 32'h0});
    end
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    total++;
    if (obs !== {5'b10000, 32'h80}) begin
      bad++; $display("FAIL ovw_release got=%h want=%h", obs, {5'b10000, 32'h80});
    end
    next_cycle();
    // release coinciding with a higher-priority source takes the new target
    set_in(0, 1, 0, 0, 1, 32'h44);
    next_cycle();
    set_in(0, 0, 1, 32'h88, 0, 0);
    @(negedge CLK);
    total++;
    if (obs !== {5'b10110, 32'h88}) begin
      bad++; $display("FAIL ovw_at_release got=%h want=%h", obs, {5'b10110, 32'h88});
    end
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    total++;
    if (obs !== {5'b00000, 32'h0}) begin
      bad++; $display("FAIL ovw_after got=%h want=%h", obs, {5'b00000, 32'h0});
    end
    next_cycle();
  endtask

  task automatic test_misalign();
    set_in(0, 0, 1, 32'h102, 1, 32'h200);
    @(negedge CLK);
    total++;
    if (obs !== {5'b00001, 32'h0}) begin
      bad++; $display("FAIL misalign_br got=%h want=%h", obs, {5'b00001, 32'h0});
    end
    next_cycle();
    set_in(0, 0, 0, 0, 1, 32'h201);
    @(negedge CLK);
    total++;
    if (obs !== {5'b00001, 32'h0}) begin
      bad++; $display("FAIL misalign_jmp got=%h want=%h", obs, {5'b00001, 32'h0});
    end
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    total++;
    if (obs !== {5'b00000, 32'h0}) begin
      bad++; $display("FAIL misalign_clear got=%h want=%h", obs, {5'b00000, 32'h0});
    end
    next_cycle();
  endtask

`ifdef PC_REDIRECT_TRAP_EN
  task automatic test_trap();
    set_in(0, 0, 1, 32'h100, 0, 0);
    trap_req = 1'b1; trap_vector = 32'h800;
    mret_req = 1'b1; mret_target = 32'h300;
    @(negedge CLK);
    total++;
    if (obs !== {5'b10110, 32'h800}) begin
      bad++; $display("FAIL trap_over_mret got=%h want=%h", obs, {5'b10110, 32'h800});
    end
    next_cycle();
    set_in(0, 0, 1, 32'h100, 0, 0);
    mret_req = 1'b1; mret_target = 32'h300;
    @(negedge CLK);
    total++;
    if (obs !== {5'b10110, 32'h300}) begin
      bad++; $display("FAIL mret_over_br got=%h want=%h", obs, {5'b10110, 32'h300});
    end
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0);
  endtask
`endif

  initial begin
    RST = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    next_cycle();
    test_reset();
    test_unstalled_branch();
    test_back_to_back();
    test_stall_hold();
    test_overwrite();
    test_misalign();
`ifdef PC_REDIRECT_TRAP_EN
    test_trap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
